inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Producer end of the instruction FIFO: accepts a host byte stream and assembles 11-byte packets into 82-bit instruction words.
- Each word uses the exact field layout the decoder consumes.
- Pushes each completed word into the instruction FIFO with full-flag backpressure.
- Sits between the host/configuration bus and the FIFO write port that feeds decode and main_controller.

Parameters:
- CNT_W, 16, width of the accepted-packet and dropped-packet counters (wrap at 2^CNT_W).

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  reset, synchronous, active-low
- host_data  input  8  packet byte, most-significant byte first
- host_valid  input  1  host_data valid this cycle
- host_ready  output  1  block can accept a byte; transfer occurs when host_valid && host_ready
- host_abort  input  1  discard any partial packet
- fifo_full  input  1  instruction FIFO full
- w_enable  output  1  FIFO write strobe, one cycle per word
- w_data  output  82  instruction word
- pkt_count  output  CNT_W  words pushed to FIFO
- drop_count  output  CNT_W  packets discarded for reserved-bit errors
- err_pulse  output  1  one-cycle pulse when a packet is dropped

Behaviour:
- Word layout:
  - [81] inst_type, [80] fill_type, [79] vertice_num, [78] layer_num
  - [77:54] color_code, [53:52] texture_code, [51:48] alpha_val, [47:0] coordinates
- Packet format: 11 bytes = 88 bits, MSB first.
  - Byte0[7:2] are reserved and must be 0; byte0[1:0] = word[81:80].
  - Bytes 1..10 = word[79:0].
- Reset (n_rst low at a clock edge):
  - state=IDLE, byte_idx=0, shift register=0, w_data=0, w_enable=0, err_pulse=0, pkt_count=0, drop_count=0, bad flag=0.
  - host_ready=1 on the first cycle after reset.
  - Reset mid-packet or mid-PUSH discards everything; no push occurs.
- States: IDLE, COLLECT, PUSH.
  - IDLE: on an accepted byte, check the reserved bits.
    - Load byte0[1:0] into the shift register, set bad = (byte0[7:2] != 0), set byte_idx=1, go to COLLECT.
  - COLLECT: each accepted byte shifts in 8 bits and increments byte_idx.
    - On acceptance of byte 10 with bad=0: latch the 82-bit word into w_data, go to PUSH.
    - On acceptance of byte 10 with bad=1: assert err_pulse next cycle, increment drop_count, go to IDLE (framing preserved, nothing pushed).
  - PUSH:
    - host_ready=0.
    - w_enable = !fifo_full (combinational from state and fifo_full).
    - On a cycle with w_enable=1: increment pkt_count, go to IDLE.
    - While fifo_full=1: hold in PUSH, w_data stable.
- host_ready = (state != PUSH) && !host_abort.
- host_abort in IDLE/COLLECT: return to IDLE, byte_idx=0, bad=0, counters unchanged.
  - If abort and valid arrive in the same cycle, abort wins and the byte is not accepted.
- host_abort in PUSH is ignored; the complete word is still pushed.
- Latency: last byte accepted at cycle N gives w_enable at N+1 if fifo_full=0. The next byte can be accepted at N+2.
- Throughput: one word per 12 cycles at most.
- w_data changes only when entering PUSH; it is held afterwards until the next word.
- Counters wrap modulo 2^CNT_W, with no saturation.
- Idle host (host_valid=0) mid-packet: wait indefinitely, no timeout.

Test Plan:
- Reset, then 11 bytes 0x03,0xFF,0x00…0x00,0x01 with fifo_full=0 -> w_enable one cycle after the 11th byte, w_data=82'h3_FF00_0000_0000_0000_0001, pkt_count=1.
- Same packet with fifo_full=1 for 5 cycles after completion -> host_ready=0 and w_enable=0 for 5 cycles, then a single w_enable with unchanged w_data.
- Byte0=0x84 followed by 10 bytes -> no w_enable, err_pulse for 1 cycle, drop_count=1. A following valid packet pushes normally.
- host_abort after 6 bytes, then a fresh 11-byte packet -> only the fresh word is pushed, with the correct value.
- host_abort coincident with host_valid in COLLECT -> byte not accepted, host_ready=0 that cycle. host_abort during PUSH -> word still pushed.
- n_rst low after 7 bytes, then 11 new bytes -> exactly one word, from the new bytes. pkt_count and drop_count reset to 0.

Source files
------------

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : inst_encoder
// Brief    : Assembles 11-byte host packets into 82-bit instruction words and
//            pushes them into the instruction FIFO under full-flag backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       host_data,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic             host_abort,
    input  logic             fifo_full,
    output logic             w_enable,
    output logic [81:0]      w_data,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             err_pulse
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PUSH    = 2'd2
    } state_t;

    localparam logic [3:0]       C_LAST_IDX = 4'd10;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_byte_idx;
    logic [73:0] r_shift;
    logic        r_bad;
    logic        w_accept;
    logic        w_last;

    assign host_ready = (r_state != S_PUSH) && !host_abort;
    assign w_enable   = (r_state == S_PUSH) && !fifo_full;
    assign w_accept   = host_valid && host_ready;
    assign w_last     = (r_state == S_COLLECT) && w_accept && (r_byte_idx == C_LAST_IDX);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (host_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    // A packet with reserved-bit errors is consumed whole so framing survives
                    w_next_state = r_bad ? S_IDLE : S_PUSH;
                end
            end
            S_PUSH: begin
                if (w_enable) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_byte_idx <= 4'd0;
            r_shift    <= 74'd0;
            r_bad      <= 1'b0;
            w_data     <= 82'd0;
            err_pulse  <= 1'b0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= {72'd0, host_data[1:0]};
                        r_bad      <= |host_data[7:2];
                        r_byte_idx <= 4'd1;
                    end
                end
                S_COLLECT: begin
                    if (host_abort) begin
                        r_byte_idx <= 4'd0;
                        r_bad      <= 1'b0;
                    end else if (w_accept) begin
                        r_shift <= {r_shift[65:0], host_data};
                        if (r_byte_idx == C_LAST_IDX) begin
                            r_byte_idx <= 4'd0;
                            r_bad      <= 1'b0;
                            if (r_bad) begin
                                err_pulse  <= 1'b1;
                                drop_count <= drop_count + C_CNT_ONE;
                            end else begin
                                w_data <= {r_shift, host_data};
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                        end
                    end
                end
                S_PUSH: begin
                    if (w_enable) begin
                        pkt_count <= pkt_count + C_CNT_ONE;
                    end
                end
                default: begin
                    r_byte_idx <= 4'd0;
                    r_bad      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_encoder
// Brief    : Randomized self-checking bench for inst_encoder; expected words
//            come from slicing each 88-bit packet, counters from a tally.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [7:0]       host_data;
    logic             host_valid;
    logic             host_ready;
    logic             host_abort;
    logic             fifo_full;
    logic             w_enable;
    logic [81:0]      w_data;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] drop_count;
    logic             err_pulse;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_pkt  = '0;
    logic [CNT_W-1:0] exp_drop = '0;

    inst_encoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_abort (host_abort),
        .fifo_full  (fifo_full),
        .w_enable   (w_enable),
        .w_data     (w_data),
        .pkt_count  (pkt_count),
        .drop_count (drop_count),
        .err_pulse  (err_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [87:0] rand_pkt(input bit good);
        logic [87:0] p;
        p = {$urandom, $urandom, $urandom};
        if (good) p[87:82] = 6'd0;
        return p;
    endfunction

    // Drives the first nbytes of pkt MSB first with random idle gaps; returns
    // one half-cycle after the final transfer edge with host_valid low.
    task automatic send_pkt(input logic [87:0] pkt, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                host_valid = 1'b0;
                host_data  = 8'($urandom);
            end
            @(negedge clk);
            host_valid = 1'b1;
            host_data  = pkt[87-8*i -: 8];
            #1;
            n_checks++;
            if (host_ready !== 1'b1 || w_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL collect byte %0d: host_ready=%b w_enable=%b, required 1/0", i, host_ready, w_enable);
            end
        end
        @(negedge clk);
        host_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        n_rst = 1'b0; host_valid = 1'b0; host_abort = 1'b0; fifo_full = 1'b0; host_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (w_enable !== 1'b0 || err_pulse !== 1'b0 || w_data !== 82'd0) begin
            n_fail++;
            $display("FAIL reset outputs: w_enable=%b err_pulse=%b w_data=%h, required 0/0/0", w_enable, err_pulse, w_data);
        end
        n_checks++;
        if (pkt_count !== '0 || drop_count !== '0) begin
            n_fail++;
            $display("FAIL reset counters: pkt=%0d drop=%0d, required 0/0", pkt_count, drop_count);
        end
        n_rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset host_ready: got %b required 1", host_ready);
        end
    endtask

    task automatic test_basic;
        send_pkt(88'h03FF_0000_0000_0000_0000_01, 11);
        n_checks++;
        if (w_enable !== 1'b1 || host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic push: w_enable=%b host_ready=%b, required 1/0", w_enable, host_ready);
        end
        n_checks++;
        if (w_data !== 82'h3_FF00_0000_0000_0000_0001) begin
            n_fail++;
            $display("FAIL basic w_data: got %h required %h", w_data, 82'h3_FF00_0000_0000_0000_0001);
        end
        exp_pkt++;
        @(negedge clk);
        #1;
        n_checks++;
        if (w_enable !== 1'b0 || pkt_count !== exp_pkt) begin
            n_fail++;
            $display("FAIL basic after push: w_enable=%b pkt_count=%0d, required 0/%0d", w_enable, pkt_count, exp_pkt);
        end
    endtask

    // Good packet held off by fifo_full for 'hold' cycles, optional abort during PUSH.
    task automatic test_backpressure(input logic [87:0] pkt, input int hold, input bit abort_in_push);
        fifo_full = (hold != 0);
        send_pkt(pkt, 11);
        host_abort = abort_in_push;
        #1;
        for (int k = 0; k < hold; k++) begin
            n_checks++;
            if (host_ready !== 1'b0 || w_enable !== 1'b0 || w_data !== pkt[81:0]) begin
                n_fail++;
                $display("FAIL stall cycle %0d: ready=%b wen=%b w_data=%h, required 0/0/%h", k, host_ready, w_enable, w_data, pkt[81:0]);
            end
            @(negedge clk);
            #1;
        end
        fifo_full = 1'b0;
        #1;
        n_checks++;
        if (w_enable !== 1'b1 || w_data !== pkt[81:0]) begin
            n_fail++;
            $display("FAIL push release: wen=%b w_data=%h, required 1/%h", w_enable, w_data, pkt[81:0]);
        end
        exp_pkt++;
        @(negedge clk);
        host_abort = 1'b0;
        #1;
        n_checks++;
        if (w_enable !== 1'b0 || pkt_count !== exp_pkt || w_data !== pkt[81:0]) begin
            n_fail++;
            $display("FAIL after push: wen=%b pkt=%0d w_data=%h, required 0/%0d/%h", w_enable, pkt_count, w_data, exp_pkt, pkt[81:0]);
        end
    endtask

    task automatic test_bad_reserved(input logic [87:0] pkt);
        logic [81:0] prev_data;
        prev_data = w_data;
        send_pkt(pkt, 11);
        exp_drop++;
        n_checks++;
        if (w_enable !== 1'b0 || err_pulse !== 1'b1 || drop_count !== exp_drop) begin
            n_fail++;
            $display("FAIL bad packet: wen=%b err=%b drop=%0d, required 0/1/%0d", w_enable, err_pulse, drop_count, exp_drop);
        end
        n_checks++;
        if (w_data !== prev_data || pkt_count !== exp_pkt) begin
            n_fail++;
            $display("FAIL bad packet side effects: w_data=%h pkt=%0d, required %h/%0d", w_data, pkt_count, prev_data, exp_pkt);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (err_pulse !== 1'b0 || w_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse width: err=%b wen=%b, required 0/0", err_pulse, w_enable);
        end
    endtask

    task automatic test_random(input int n);
        logic [87:0] p;
        for (int j = 0; j < n; j++) begin
            p = rand_pkt($urandom_range(0, 3) != 0);
            if (p[87:82] != 6'd0) test_bad_reserved(p);
            else                  test_backpressure(p, $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_abort(input bit coincident);
        send_pkt(rand_pkt(1'b1), coincident ? 3 : 6);
        host_abort = 1'b1;
        host_valid = coincident;
        host_data  = 8'($urandom);
        #1;
        n_checks++;
        if (host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort host_ready: got %b required 0", host_ready);
        end
        @(negedge clk);
        host_abort = 1'b0;
        host_valid = 1'b0;
        test_backpressure(rand_pkt(1'b1), 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        send_pkt(rand_pkt(1'b1), 7);
        n_rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (pkt_count !== '0 || drop_count !== '0 || w_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL mid reset: pkt=%0d drop=%0d wen=%b, required 0/0/0", pkt_count, drop_count, w_enable);
        end
        n_rst    = 1'b1;
        exp_pkt  = '0;
        exp_drop = '0;
        test_backpressure(rand_pkt(1'b1), 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure(88'h03FF_0000_0000_0000_0000_01, 5, 1'b0);
        test_bad_reserved({8'h84, 80'h1234_5678_9ABC_DEF0_1357});
        test_backpressure(rand_pkt(1'b1), 0, 1'b0);
        test_abort(1'b0);
        test_abort(1'b1);
        test_backpressure(rand_pkt(1'b1), 2, 1'b1);
        test_random(20);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
